// File: rtl/mct_pkg.sv
// Shared types and helpers for the byte-serialising RAM controller.
package mct_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_LAST = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MM   = 2'd2
  } grant_t;

  localparam logic [1:0] CU_B = 2'd0;
  localparam logic [1:0] CU_H = 2'd1;
  localparam logic [1:0] CU_W = 2'd3;

  // Index of the final byte of a transfer; cu=2 is promoted to a word.
  function automatic logic [1:0] last_idx(input logic [1:0] cu);
    case (cu)
      CU_B:    last_idx = 2'd0;
      CU_H:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MM requests onto a byte-wide synchronous RAM, issuing
// one byte per cycle and assembling read bytes into a buffer.
module mem_ctrl
  import mct_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_mct_e,
  input  logic [ADDR_W-1:0] if_mct_a,
  input  logic              if_mct_clr,
  output logic              if_mct_ok,
  output logic [31:0]       if_mct_n_o,
  input  logic              mm_mct_e,
  input  logic [ADDR_W-1:0] mm_mct_a,
  input  logic              mm_mct_wr,
  input  logic [1:0]        mm_mct_cu,
  input  logic [31:0]       mm_mct_n_i,
  output logic              mm_mct_ok,
  output logic [31:0]       mm_mct_n_o,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_t            state_r;
  grant_t            grant_r;
  logic [1:0]        cnt_r;
  logic [1:0]        last_r;
  logic [ADDR_W-1:0] a_r;
  logic [31:0]       wdata_r;
  logic [31:0]       buf_r;
  logic              if_ok_r;
  logic              mm_ok_r;
  logic [31:0]       if_n_r;
  logic [31:0]       mm_n_r;
  logic [ADDR_W-1:0] ram_a_r;
  logic              ram_wr_r;
  logic [7:0]        ram_dout_r;

  logic [1:0]        cnt_inc_s;
  logic [ADDR_W-1:0] addr_next_s;
  logic [31:0]       cap_s;

  assign cnt_inc_s   = cnt_r + 2'd1;
  assign addr_next_s = a_r + ADDR_W'(cnt_inc_s);

  // Buffer with this cycle's RAM byte folded in (byte cnt-1 arrives now).
  always_comb begin
    cap_s = buf_r;
    case (cnt_r)
      2'd1:    cap_s[7:0]   = ram_din;
      2'd2:    cap_s[15:8]  = ram_din;
      2'd3:    cap_s[23:16] = ram_din;
      default: cap_s = buf_r;
    endcase
  end

  // Arbitration and byte-sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      grant_r    <= GNT_NONE;
      cnt_r      <= 2'd0;
      last_r     <= 2'd0;
      a_r        <= {ADDR_W{1'b0}};
      wdata_r    <= 32'h0000_0000;
      buf_r      <= 32'h0000_0000;
      if_ok_r    <= 1'b0;
      mm_ok_r    <= 1'b0;
      if_n_r     <= 32'h0000_0000;
      mm_n_r     <= 32'h0000_0000;
      ram_a_r    <= {ADDR_W{1'b0}};
      ram_wr_r   <= 1'b0;
      ram_dout_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 2'd0;
          buf_r <= 32'h0000_0000;
          if (mm_mct_e) begin
            grant_r    <= GNT_MM;
            a_r        <= mm_mct_a;
            last_r     <= last_idx(mm_mct_cu);
            wdata_r    <= mm_mct_n_i;
            state_r    <= mm_mct_wr ? ST_WR : ST_RD;
            ram_a_r    <= mm_mct_a;
            ram_wr_r   <= mm_mct_wr;
            ram_dout_r <= mm_mct_wr ? mm_mct_n_i[7:0] : 8'h00;
          end else if (if_mct_e && !if_mct_clr) begin
            grant_r    <= GNT_IF;
            a_r        <= if_mct_a;
            last_r     <= CU_W;
            wdata_r    <= 32'h0000_0000;
            state_r    <= ST_RD;
            ram_a_r    <= if_mct_a;
            ram_wr_r   <= 1'b0;
            ram_dout_r <= 8'h00;
          end else begin
            state_r    <= ST_IDLE;
            ram_a_r    <= {ADDR_W{1'b0}};
            ram_wr_r   <= 1'b0;
            ram_dout_r <= 8'h00;
          end
        end
        ST_RD: begin
          if (grant_r == GNT_IF && if_mct_clr) begin
            state_r <= ST_IDLE;
            grant_r <= GNT_NONE;
            cnt_r   <= 2'd0;
            buf_r   <= 32'h0000_0000;
            ram_a_r <= {ADDR_W{1'b0}};
          end else begin
            buf_r <= cap_s;
            if (cnt_r == last_r) begin
              state_r <= ST_LAST;
              if (grant_r == GNT_IF) begin
                if_ok_r <= 1'b1;
                if_n_r  <= cap_s;
              end else begin
                mm_ok_r <= 1'b1;
                mm_n_r  <= cap_s;
              end
            end else begin
              cnt_r   <= cnt_inc_s;
              ram_a_r <= addr_next_s;
            end
          end
        end
        ST_WR: begin
          if (cnt_r == last_r) begin
            state_r    <= ST_LAST;
            ram_wr_r   <= 1'b0;
            ram_dout_r <= 8'h00;
            mm_ok_r    <= 1'b1;
            mm_n_r     <= buf_r;
          end else begin
            cnt_r      <= cnt_inc_s;
            ram_a_r    <= addr_next_s;
            ram_dout_r <= byte_sel(wdata_r, cnt_inc_s);
          end
        end
        ST_LAST: begin
          state_r    <= ST_IDLE;
          grant_r    <= GNT_NONE;
          cnt_r      <= 2'd0;
          buf_r      <= 32'h0000_0000;
          if_ok_r    <= 1'b0;
          mm_ok_r    <= 1'b0;
          ram_a_r    <= {ADDR_W{1'b0}};
          ram_wr_r   <= 1'b0;
          ram_dout_r <= 8'h00;
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= GNT_NONE;
        end
      endcase
    end
  end

  // A flush arriving in the ok cycle still suppresses the IF strobe.
  assign if_mct_ok  = if_ok_r & ~if_mct_clr;
  assign mm_mct_ok  = mm_ok_r;
  assign if_mct_n_o = if_n_r;
  assign mm_mct_n_o = mm_n_r;
  assign ram_a      = ram_a_r;
  assign ram_wr     = ram_wr_r;
  assign ram_dout   = ram_dout_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cycle-exact sequences plus a
// table of transfers checked through a scoreboard against a reference memory.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_mct_e;
  logic [31:0] if_mct_a;
  logic        if_mct_clr;
  logic        if_mct_ok;
  logic [31:0] if_mct_n_o;
  logic        mm_mct_e;
  logic [31:0] mm_mct_a;
  logic        mm_mct_wr;
  logic [1:0]  mm_mct_cu;
  logic [31:0] mm_mct_n_i;
  logic        mm_mct_ok;
  logic [31:0] mm_mct_n_o;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int tests;
  int fails;

  bit [7:0] mem [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];

  typedef struct {
    logic        is_if;
    logic        wr;
    logic [1:0]  cu;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
  } vec_t;

  typedef struct {
    logic        is_if;
    logic        is_rd;
    logic [31:0] no;
    logic [7:0]  din;
    int          lat;
  } sb_t;

  vec_t vecs [10];
  sb_t  sbq [$];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_mct_e(if_mct_e), .if_mct_a(if_mct_a), .if_mct_clr(if_mct_clr),
    .if_mct_ok(if_mct_ok), .if_mct_n_o(if_mct_n_o),
    .mm_mct_e(mm_mct_e), .mm_mct_a(mm_mct_a), .mm_mct_wr(mm_mct_wr),
    .mm_mct_cu(mm_mct_cu), .mm_mct_n_i(mm_mct_n_i),
    .mm_mct_ok(mm_mct_ok), .mm_mct_n_o(mm_mct_n_o),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [7:0] rd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Synchronous byte RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    ram_din <= rd(ram_a);
    if (ram_wr) mem[ram_a] = ram_dout;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    if_mct_e = 1'b0; if_mct_a = 32'h0; if_mct_clr = 1'b0;
    mm_mct_e = 1'b0; mm_mct_a = 32'h0; mm_mct_wr = 1'b0;
    mm_mct_cu = 2'd0; mm_mct_n_i = 32'h0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ram_a"}, ram_a, 32'h0);
    chk({nm, "_ram_wr"}, {31'h0, ram_wr}, 32'h0);
    chk({nm, "_ram_dout"}, {24'h0, ram_dout}, 32'h0);
    chk({nm, "_if_ok"}, {31'h0, if_mct_ok}, 32'h0);
    chk({nm, "_mm_ok"}, {31'h0, mm_mct_ok}, 32'h0);
    chk({nm, "_if_n_o"}, if_mct_n_o, 32'h0);
    chk({nm, "_mm_n_o"}, mm_mct_n_o, 32'h0);
  endtask

  task automatic preload(input bit [31:0] a, input bit [7:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Drive one table transfer and push its expected completion.
  task automatic issue(input vec_t v);
    sb_t e;
    int  n;
    n = v.is_if ? 4 : (v.cu == 2'd0 ? 1 : (v.cu == 2'd1 ? 2 : 4));
    e.is_if = v.is_if;
    e.is_rd = v.is_if | ~v.wr;
    e.lat   = v.lat;
    e.no    = 32'h0;
    e.din   = 8'h00;
    if (!e.is_rd) begin
      for (int k = 0; k < n; k++) ref_mem[v.a + 32'(k)] = 8'(v.wd >> (8 * k));
    end else begin
      for (int k = 0; k < n - 1; k++) e.no[8*k +: 8] = ref_rd(v.a + 32'(k));
      e.din = ref_rd(v.a + 32'(n - 1));
    end
    sbq.push_back(e);
    if (v.is_if) begin
      if_mct_e = 1'b1; if_mct_a = v.a;
    end else begin
      mm_mct_e = 1'b1; mm_mct_a = v.a; mm_mct_wr = v.wr;
      mm_mct_cu = v.cu; mm_mct_n_i = v.wd;
    end
  endtask

  initial begin
    sb_t e;
    bit  got;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    idle_inputs();
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h8, 8'h5A);   preload(32'h9, 8'hC3);

    vecs[0] = '{1'b0, 1'b1, 2'd3, 32'h0000_0200, 32'h0403_0201, 5};
    vecs[1] = '{1'b0, 1'b0, 2'd3, 32'h0000_0200, 32'h0, 5};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 32'h0000_0300, 32'h0000_BEEF, 3};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 32'h0000_0301, 32'h0, 2};
    vecs[4] = '{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0, 5};
    vecs[5] = '{1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0, 5};
    vecs[6] = '{1'b0, 1'b0, 2'd1, 32'h0000_0301, 32'h0, 3};
    vecs[7] = '{1'b0, 1'b1, 2'd3, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 5};
    vecs[8] = '{1'b0, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0, 5};
    vecs[9] = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0, 5};

    @(negedge clk);
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b1;

    // IF word read at 0x100: one address per cycle, ok at c+5.
    if_mct_e = 1'b1; if_mct_a = 32'h100;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 4) chk("if_rd_ram_a", ram_a, 32'h100 + 32'(k - 1));
      chk("if_rd_ram_wr", {31'h0, ram_wr}, 32'h0);
      chk("if_rd_ok", {31'h0, if_mct_ok}, {31'h0, k == 5});
    end
    chk("if_rd_n_o", if_mct_n_o, 32'h0033_2211);
    chk("if_rd_din", {24'h0, ram_din}, 32'h44);
    idle_inputs();
    step();
    chk("if_rd_ok_drop", {31'h0, if_mct_ok}, 32'h0);

    // MM byte write at 0x30004.
    mm_mct_e = 1'b1; mm_mct_a = 32'h30004; mm_mct_wr = 1'b1;
    mm_mct_cu = 2'd0; mm_mct_n_i = 32'h0000_00A5;
    step();
    chk("bw_ram_wr", {31'h0, ram_wr}, 32'h1);
    chk("bw_ram_a", ram_a, 32'h30004);
    chk("bw_ram_dout", {24'h0, ram_dout}, 32'hA5);
    chk("bw_ok_early", {31'h0, mm_mct_ok}, 32'h0);
    step();
    chk("bw_ok", {31'h0, mm_mct_ok}, 32'h1);
    chk("bw_ram_wr_last", {31'h0, ram_wr}, 32'h0);
    idle_inputs();
    step();
    chk("bw_mem", {24'h0, rd(32'h30004)}, 32'hA5);
    chk("bw_mem_below", {24'h0, rd(32'h30003)}, 32'h0);
    chk("bw_mem_above", {24'h0, rd(32'h30005)}, 32'h0);
    ref_mem[32'h30004] = 8'hA5;

    // MM half read and IF read requested together: MM first, then IF.
    mm_mct_e = 1'b1; mm_mct_a = 32'h8; mm_mct_wr = 1'b0; mm_mct_cu = 2'd1;
    if_mct_e = 1'b1; if_mct_a = 32'h100;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("arb_mm_ok", {31'h0, mm_mct_ok}, {31'h0, k == 3});
      chk("arb_if_ok", {31'h0, if_mct_ok}, {31'h0, k == 9});
      if (k == 3) begin
        chk("arb_mm_n_o", mm_mct_n_o, 32'h0000_005A);
        chk("arb_mm_din", {24'h0, ram_din}, 32'hC3);
        mm_mct_e = 1'b0;
      end
      if (k == 5) chk("arb_if_ram_a", ram_a, 32'h100);
    end
    chk("arb_if_n_o", if_mct_n_o, 32'h0033_2211);
    chk("arb_mm_n_o_hold", mm_mct_n_o, 32'h0000_005A);
    idle_inputs();
    step();

    // IF read flushed at c+2; a pending MM byte read is granted next IDLE.
    if_mct_e = 1'b1; if_mct_a = 32'h100;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("clr_if_ok", {31'h0, if_mct_ok}, 32'h0);
      chk("clr_ram_wr", {31'h0, ram_wr}, 32'h0);
      if (k == 2) begin
        if_mct_clr = 1'b1;
        mm_mct_e = 1'b1; mm_mct_a = 32'h8; mm_mct_wr = 1'b0; mm_mct_cu = 2'd0;
      end
      if (k == 3) begin
        chk("clr_idle_ram_a", ram_a, 32'h0);
        if_mct_clr = 1'b0; if_mct_e = 1'b0;
      end
      if (k == 4) chk("clr_mm_ram_a", ram_a, 32'h8);
      if (k == 5) begin
        chk("clr_mm_ok", {31'h0, mm_mct_ok}, 32'h1);
        chk("clr_mm_din", {24'h0, ram_din}, 32'h5A);
      end
    end
    idle_inputs();
    step();

    // Reset in RD at cnt=2, then the held IF request restarts from byte 0.
    if_mct_e = 1'b1; if_mct_a = 32'h100;
    step(); step(); step();
    chk("rst_mid_ram_a", ram_a, 32'h102);
    rst = 1'b0;
    step();
    chk_all_zero("rst_mid");
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) chk("rst_restart_ram_a", ram_a, 32'h100);
      chk("rst_restart_ok", {31'h0, if_mct_ok}, {31'h0, k == 5});
    end
    chk("rst_restart_n_o", if_mct_n_o, 32'h0033_2211);
    idle_inputs();
    step();

    // Table of transfers checked through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i]);
      got = 1'b0;
      for (int s = 1; s <= 20 && !got; s++) begin
        step();
        if (vecs[i].is_if) chk("tbl_wrong_port_ok", {31'h0, mm_mct_ok}, 32'h0);
        else chk("tbl_wrong_port_ok", {31'h0, if_mct_ok}, 32'h0);
        if ((vecs[i].is_if && if_mct_ok) || (!vecs[i].is_if && mm_mct_ok)) begin
          got = 1'b1;
          e = sbq.pop_front();
          chk("tbl_latency", 32'(s), 32'(e.lat));
          chk("tbl_n_o", e.is_if ? if_mct_n_o : mm_mct_n_o, e.no);
          if (e.is_rd) chk("tbl_din", {24'h0, ram_din}, {24'h0, e.din});
        end
      end
      if (!got) begin
        chk("tbl_timeout", 32'h0, 32'h1);
        void'(sbq.pop_front());
      end
      idle_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
